// File: rtl/hls_deadlock_monitor_nproc_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
// Build option: DEADLOCK_MON_SNAPSHOT_EN enables first-event snapshot capture.
package hls_deadlock_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  localparam int TIME_W_DEF = 32;

  // Persistence counter must hold the value DEBOUNCE itself.
  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/hls_deadlock_monitor_nproc_if.sv
// Status bundle between a dataflow region (master) and its deadlock monitor (slave).
// Build option: DEADLOCK_MON_SNAPSHOT_EN makes the snapshot fields live.
interface hls_deadlock_monitor_nproc_if #(
  parameter int NUM_PROC = 3,
  parameter int TIME_W   = hls_deadlock_mon_pkg::TIME_W_DEF
);
  import hls_deadlock_mon_pkg::*;

  // Level signals only, no valid/ready: every field is meaningful on every
  // clock and the monitor samples the status vectors each rising edge.
  logic [NUM_PROC-1:0] axis_block_sigs;
  logic [NUM_PROC-1:0] inst_idle_sigs;
  logic [NUM_PROC-1:0] inst_block_sigs;
  logic                clear_sticky;
  logic                block;
  logic                block_seen;
  logic [NUM_PROC-1:0] snap_axis_vec;
  logic [NUM_PROC-1:0] snap_chan_vec;
  logic [TIME_W-1:0]   snap_time;
  state_t              dbg_state;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear_sticky,
    input  block, block_seen, snap_axis_vec, snap_chan_vec, snap_time, dbg_state
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear_sticky,
    output block, block_seen, snap_axis_vec, snap_chan_vec, snap_time, dbg_state
  );

endinterface

// File: rtl/hls_deadlock_monitor_nproc_debounce.sv
// Persistence filter: cand must hold DEBOUNCE consecutive cycles before block asserts.
// entry is a combinational look-ahead pulse for the edge that enters S_BLOCKED.
module hls_deadlock_mon_debounce
  import hls_deadlock_mon_pkg::*;
#(
  parameter int DEBOUNCE = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   cand,
  output logic   block,
  output logic   entry,
  output state_t state
);

  localparam int              CW      = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE);

  logic [CW-1:0] cnt;

  // S_IDLE holds cnt at 0, so one compare covers both IDLE and ARM.
  assign entry = (state != S_BLOCKED) && cand && (cnt == CNT_MAX - 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      block <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ARM: begin
          if (cand) begin
            cnt <= cnt + 1'b1;
            if (entry) begin
              state <= S_BLOCKED;
              block <= 1'b1;
            end else begin
              state <= S_ARM;
            end
          end else begin
            cnt   <= '0;
            state <= S_IDLE;
            block <= 1'b0;
          end
        end
        S_BLOCKED: begin
          if (!cand) begin
            cnt   <= '0;
            state <= S_IDLE;
            block <= 1'b0;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
          block <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_nproc.sv
// Region-wide deadlock monitor: all processes stopped with at least one on an AXIS port.
// Build option: DEADLOCK_MON_SNAPSHOT_EN adds first-event snapshot and timestamp.
module hls_deadlock_monitor_nproc
  import hls_deadlock_mon_pkg::*;
#(
  parameter int                  NUM_PROC  = 3,
  parameter logic [NUM_PROC-1:0] AXIS_MASK = {NUM_PROC{1'b1}},
  parameter int                  DEBOUNCE  = 1,
  parameter int                  TIME_W    = TIME_W_DEF
) (
  input logic                          clock,
  input logic                          reset,
  hls_deadlock_monitor_nproc_if.slave  mon
);

  logic [NUM_PROC-1:0] axis_eff;
  logic [NUM_PROC-1:0] stop;
  logic                cand;
  logic                entry;
  logic                block_q;
  logic                seen_q;
  state_t              state;

  assign axis_eff = mon.axis_block_sigs & AXIS_MASK;
  assign stop     = mon.inst_idle_sigs | mon.inst_block_sigs | axis_eff;
  assign cand     = (|axis_eff) & (&stop);

  hls_deadlock_mon_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .cand  (cand),
    .block (block_q),
    .entry (entry),
    .state (state)
  );

  // A new event wins over a simultaneous clear so no deadlock goes unreported.
  always_ff @(posedge clock) begin
    if (reset)             seen_q <= 1'b0;
    else if (entry)        seen_q <= 1'b1;
    else if (mon.clear_sticky) seen_q <= 1'b0;
  end

  assign mon.block      = block_q;
  assign mon.block_seen = seen_q;
  assign mon.dbg_state  = state;

`ifdef DEADLOCK_MON_SNAPSHOT_EN
  logic [TIME_W-1:0]   time_cnt;
  logic [NUM_PROC-1:0] snap_axis_q;
  logic [NUM_PROC-1:0] snap_chan_q;
  logic [TIME_W-1:0]   snap_time_q;

  always_ff @(posedge clock) begin
    if (reset)                   time_cnt <= '0;
    else if (time_cnt != '1)     time_cnt <= time_cnt + 1'b1;
  end

  // Only the first event after reset/clear is kept; a clear re-arms capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_axis_q <= '0;
      snap_chan_q <= '0;
      snap_time_q <= '0;
    end else if (entry && (!seen_q || mon.clear_sticky)) begin
      snap_axis_q <= mon.axis_block_sigs;
      snap_chan_q <= mon.inst_block_sigs;
      snap_time_q <= time_cnt;
    end else if (mon.clear_sticky) begin
      snap_axis_q <= '0;
      snap_chan_q <= '0;
      snap_time_q <= '0;
    end
  end

  assign mon.snap_axis_vec = snap_axis_q;
  assign mon.snap_chan_vec = snap_chan_q;
  assign mon.snap_time     = snap_time_q;
`else
  assign mon.snap_axis_vec = {NUM_PROC{1'b0}};
  assign mon.snap_chan_vec = {NUM_PROC{1'b0}};
  assign mon.snap_time     = {TIME_W{1'b0}};
`endif

endmodule

// File: tb/tb_hls_deadlock_monitor_nproc.sv
// Directed bench: three monitors (DEBOUNCE 1/4/2) share one stimulus stream.
// Snapshot expectations collapse to 0 unless DEADLOCK_MON_SNAPSHOT_EN is defined.
module tb_hls_deadlock_monitor_nproc;
  import hls_deadlock_mon_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] axis, idle, chan;
  logic       clr;
  int         cyc;
  int         n_vec;
  int         n_bad;

  hls_deadlock_monitor_nproc_if #(.NUM_PROC(3), .TIME_W(32)) if_a ();
  hls_deadlock_monitor_nproc_if #(.NUM_PROC(3), .TIME_W(4))  if_b ();
  hls_deadlock_monitor_nproc_if #(.NUM_PROC(3), .TIME_W(32)) if_c ();

  assign if_a.axis_block_sigs = axis;
  assign if_a.inst_idle_sigs  = idle;
  assign if_a.inst_block_sigs = chan;
  assign if_a.clear_sticky    = clr;
  assign if_b.axis_block_sigs = axis;
  assign if_b.inst_idle_sigs  = idle;
  assign if_b.inst_block_sigs = chan;
  assign if_b.clear_sticky    = clr;
  assign if_c.axis_block_sigs = axis;
  assign if_c.inst_idle_sigs  = idle;
  assign if_c.inst_block_sigs = chan;
  assign if_c.clear_sticky    = clr;

  hls_deadlock_monitor_nproc #(
    .NUM_PROC(3), .AXIS_MASK(3'b101), .DEBOUNCE(1), .TIME_W(32)
  ) dut_a (.clock(clock), .reset(reset), .mon(if_a));

  hls_deadlock_monitor_nproc #(
    .NUM_PROC(3), .AXIS_MASK(3'b111), .DEBOUNCE(4), .TIME_W(4)
  ) dut_b (.clock(clock), .reset(reset), .mon(if_b));

  hls_deadlock_monitor_nproc #(
    .NUM_PROC(3), .AXIS_MASK(3'b111), .DEBOUNCE(2), .TIME_W(32)
  ) dut_c (.clock(clock), .reset(reset), .mon(if_c));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v);
`ifdef DEADLOCK_MON_SNAPSHOT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] i, input logic [2:0] c);
    axis = a;
    idle = i;
    chan = c;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    clr   = 1'b0;
    drive(3'b000, 3'b000, 3'b000);
    repeat (3) @(posedge clock);
    #1;
    check("rst_a_block", 32'(if_a.block), 0);
    check("rst_a_seen", 32'(if_a.block_seen), 0);
    check("rst_a_state", 32'(if_a.dbg_state), 32'(S_IDLE));
    check("rst_b_block", 32'(if_b.block), 0);
    check("rst_c_seen", 32'(if_c.block_seen), 0);
    check("rst_a_snap_time", if_a.snap_time, 0);
    check("rst_c_snap_axis", 32'(if_c.snap_axis_vec), 0);
    reset = 1'b0;
    cyc   = 0;

    // Basic detection: all three processes stopped, process 0 on AXIS.
    step(5);
    drive(3'b001, 3'b010, 3'b100);
    step(1);                                    // cyc 6
    check("a_block_k1", 32'(if_a.block), 1);
    check("a_seen_k1", 32'(if_a.block_seen), 1);
    check("a_state_blk", 32'(if_a.dbg_state), 32'(S_BLOCKED));
    check("a_snap_axis", 32'(if_a.snap_axis_vec), sx(32'h1));
    check("a_snap_chan", 32'(if_a.snap_chan_vec), sx(32'h4));
    check("a_snap_time", if_a.snap_time, sx(32'd5));
    check("c_block_early", 32'(if_c.block), 0);
    check("c_state_arm", 32'(if_c.dbg_state), 32'(S_ARM));
    check("b_block_early", 32'(if_b.block), 0);
    step(1);                                    // cyc 7
    check("c_block_k2", 32'(if_c.block), 1);
    check("c_snap_time", if_c.snap_time, sx(32'd6));
    check("b_state_arm", 32'(if_b.dbg_state), 32'(S_ARM));
    step(2);                                    // cyc 9
    check("b_block_k4", 32'(if_b.block), 1);
    check("b_seen_k4", 32'(if_b.block_seen), 1);
    check("b_snap_time", if_b.snap_time, sx(32'd8));

    // Process 1 leaves idle: live block drops next cycle, sticky stays.
    drive(3'b001, 3'b000, 3'b100);
    step(1);                                    // cyc 10
    check("a_block_drop", 32'(if_a.block), 0);
    check("b_block_drop", 32'(if_b.block), 0);
    check("c_block_drop", 32'(if_c.block), 0);
    check("a_seen_hold", 32'(if_a.block_seen), 1);
    check("b_state_idle", 32'(if_b.dbg_state), 32'(S_IDLE));
    clr = 1'b1;
    step(1);                                    // cyc 11
    clr = 1'b0;
    check("a_seen_clr", 32'(if_a.block_seen), 0);
    check("c_seen_clr", 32'(if_c.block_seen), 0);
    check("a_snap_axis_clr", 32'(if_a.snap_axis_vec), 0);
    check("b_snap_time_clr", if_b.snap_time, 0);

    // Only the masked process 1 is on AXIS: monitor A must not fire.
    drive(3'b010, 3'b101, 3'b000);
    step(1);                                    // cyc 12
    check("a_mask_block", 32'(if_a.block), 0);
    check("a_mask_state", 32'(if_a.dbg_state), 32'(S_IDLE));
    check("c_unmask_arm", 32'(if_c.dbg_state), 32'(S_ARM));
    step(1);                                    // cyc 13
    check("a_mask_block2", 32'(if_a.block), 0);
    check("c_unmask_block", 32'(if_c.block), 1);
    check("c_snap_axis2", 32'(if_c.snap_axis_vec), sx(32'h2));
    check("c_snap_time2", if_c.snap_time, sx(32'd12));
    drive(3'b000, 3'b000, 3'b000);
    step(1);                                    // cyc 14
    check("c_block_drop2", 32'(if_c.block), 0);
    clr = 1'b1;
    step(1);                                    // cyc 15
    clr = 1'b0;
    check("c_seen_clr2", 32'(if_c.block_seen), 0);

    // Burst of 3, gap of 1, burst of 4+ against DEBOUNCE=4.
    drive(3'b001, 3'b110, 3'b000);
    step(3);                                    // cyc 18
    check("b_burst1_block", 32'(if_b.block), 0);
    check("b_burst1_arm", 32'(if_b.dbg_state), 32'(S_ARM));
    check("a_burst1_block", 32'(if_a.block), 1);
    drive(3'b000, 3'b000, 3'b000);
    step(1);                                    // cyc 19
    check("a_gap_block", 32'(if_a.block), 0);
    check("b_gap_idle", 32'(if_b.dbg_state), 32'(S_IDLE));
    drive(3'b001, 3'b110, 3'b000);
    step(3);                                    // cyc 22
    check("b_burst2_early", 32'(if_b.block), 0);
    clr = 1'b1;                                 // coincides with B's entry edge
    step(1);                                    // cyc 23
    clr = 1'b0;
    check("b_burst2_block", 32'(if_b.block), 1);
    check("b_seen_vs_clr", 32'(if_b.block_seen), 1);
    check("b_snap_sat", if_b.snap_time, sx(32'd15));
    check("b_snap_axis3", 32'(if_b.snap_axis_vec), sx(32'h1));
    check("a_seen_clr_blk", 32'(if_a.block_seen), 0);
    check("a_block_held", 32'(if_a.block), 1);
    check("c_seen_clr_blk", 32'(if_c.block_seen), 0);
    check("c_snap_clr_blk", 32'(if_c.snap_axis_vec), 0);

    // Reset in the middle of B's count.
    drive(3'b000, 3'b000, 3'b000);
    step(1);                                    // cyc 24
    drive(3'b001, 3'b110, 3'b000);
    step(2);                                    // cyc 26
    check("b_arm_pre_rst", 32'(if_b.dbg_state), 32'(S_ARM));
    check("a_seen_pre_rst", 32'(if_a.block_seen), 1);
    reset = 1'b1;
    clr   = 1'b1;
    step(1);
    check("rst2_a_block", 32'(if_a.block), 0);
    check("rst2_a_seen", 32'(if_a.block_seen), 0);
    check("rst2_a_snap_axis", 32'(if_a.snap_axis_vec), 0);
    check("rst2_b_state", 32'(if_b.dbg_state), 32'(S_IDLE));
    check("rst2_b_seen", 32'(if_b.block_seen), 0);
    check("rst2_b_snap_time", if_b.snap_time, 0);
    reset = 1'b0;
    clr   = 1'b0;
    cyc   = 0;
    step(3);                                    // cyc 3
    check("b_rearm_block", 32'(if_b.block), 0);
    check("b_rearm_state", 32'(if_b.dbg_state), 32'(S_ARM));
    check("a_post_rst_time", if_a.snap_time, sx(32'd0));
    check("c_post_rst_time", if_c.snap_time, sx(32'd1));
    step(1);                                    // cyc 4
    check("b_rearm_full", 32'(if_b.block), 1);
    check("b_post_rst_time", if_b.snap_time, sx(32'd3));
    drive(3'b000, 3'b000, 3'b000);

    // First-event snapshot on C, later event ignored, clear re-arms.
    step(46);                                   // cyc 50
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(47);                                   // cyc 98
    drive(3'b001, 3'b000, 3'b110);
    step(2);                                    // cyc 100
    check("c_ev1_block", 32'(if_c.block), 1);
    check("c_ev1_axis", 32'(if_c.snap_axis_vec), sx(32'h1));
    check("c_ev1_chan", 32'(if_c.snap_chan_vec), sx(32'h6));
    check("c_ev1_time", if_c.snap_time, sx(32'd99));
    drive(3'b000, 3'b000, 3'b000);
    step(1);                                    // cyc 101
    check("c_ev1_drop", 32'(if_c.block), 0);
    check("c_ev1_seen", 32'(if_c.block_seen), 1);
    step(97);                                   // cyc 198
    drive(3'b001, 3'b010, 3'b100);
    step(2);                                    // cyc 200
    check("c_ev2_block", 32'(if_c.block), 1);
    check("c_ev2_time", if_c.snap_time, sx(32'd99));
    check("c_ev2_chan", 32'(if_c.snap_chan_vec), sx(32'h6));
    drive(3'b000, 3'b000, 3'b000);
    step(1);                                    // cyc 201
    clr = 1'b1;
    step(1);                                    // cyc 202
    clr = 1'b0;
    check("c_clr_seen", 32'(if_c.block_seen), 0);
    check("c_clr_time", if_c.snap_time, 0);
    check("c_clr_chan", 32'(if_c.snap_chan_vec), 0);
    step(8);                                    // cyc 210
    drive(3'b001, 3'b110, 3'b000);
    step(2);                                    // cyc 212
    check("c_ev3_block", 32'(if_c.block), 1);
    check("c_ev3_seen", 32'(if_c.block_seen), 1);
    check("c_ev3_time", if_c.snap_time, sx(32'd211));
    check("c_ev3_axis", 32'(if_c.snap_axis_vec), sx(32'h1));
    check("c_ev3_chan", 32'(if_c.snap_chan_vec), 0);
    drive(3'b000, 3'b000, 3'b000);
    step(1);
    check("c_ev3_drop", 32'(if_c.block), 0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_monitor_nproc.md
# hls_deadlock_monitor_nproc

Parametrised deadlock monitor for one HLS dataflow region with any number of processes and per-process AXI-Stream blocking sources. It qualifies the region-wide "all processes stopped, at least one on an AXIS port" condition with a configurable persistence filter, and provides a sticky flag plus optional first-event diagnostics. It sits beside the dataflow instance in the generated top and feeds the top-level deadlock reporting tree in place of the fixed-size per-instance monitors.

## Interface
- NUM_PROC, 3: number of dataflow processes monitored (≥1).
- AXIS_MASK, {NUM_PROC{1'b1}}: bit i set = process i owns at least one AXIS port; a clear bit forces that process's AXIS-block term to 0.
- DEBOUNCE, 1: consecutive candidate cycles required before `block` asserts (≥1); 1 gives single-cycle registered behaviour.
- TIME_W, 32: width of the snapshot timestamp counter.

- clock  in  1  single clock. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- axis_block_sigs  in  NUM_PROC  bit i: process i stalled on an AXIS read/write.
- inst_idle_sigs  in  NUM_PROC  bit i: process i idle.
- inst_block_sigs  in  NUM_PROC  bit i: process i blocked on an internal FIFO/PIPO channel.
- clear_sticky  in  1  one-cycle pulse; clears `block_seen` and snapshot outputs.
- block  out  1  qualified deadlock, live (drops when the condition clears).
- block_seen  out  1  sticky: `block` has been high since last reset/clear.
- snap_axis_vec  out  NUM_PROC  AXIS-block vector captured at first `block` assertion.
- snap_chan_vec  out  NUM_PROC  channel-block vector captured at the same point.
- snap_time  out  TIME_W  cycle count since reset at the capture point.

## Operation
- axis_eff[i] = axis_block_sigs[i] & AXIS_MASK[i]; stop[i] = idle[i] | chan_block[i] | axis_eff[i].
- cand = (|axis_eff) & (&stop). Purely combinational, never registered directly to an output.
- Persistence counter `cnt`, width $clog2(DEBOUNCE+1), saturates at DEBOUNCE.
- FSM states: S_IDLE (cnt=0), S_ARM (0<cnt<DEBOUNCE), S_BLOCKED (block=1).
  - S_IDLE: cand → cnt=1; DEBOUNCE=1 → S_BLOCKED, otherwise S_ARM.
  - S_ARM: cand → cnt+1; reaching DEBOUNCE → S_BLOCKED. !cand → cnt=0, S_IDLE.
  - S_BLOCKED: cand → stay, cnt held at DEBOUNCE. !cand → S_IDLE, cnt=0.
- `block` is 1 exactly in S_BLOCKED (registered).
- `block_seen` is set on every S_BLOCKED entry and cleared by `clear_sticky`. A set and a clear in the same cycle leave it set.
- Snapshot (macro-enabled) captures on S_BLOCKED entry only while `block_seen` is 0, so only the first event is kept. `clear_sticky` zeroes the snapshot and re-arms capture.
- Free-running timestamp counter starts at 0 after reset, increments every cycle and saturates at all-ones (no wrap).
- Reset mid-count or mid-block: all state returns to S_IDLE next edge; `clear_sticky` is ignored during reset.

## Timing
- Reset values: block=0, block_seen=0, snap_axis_vec=0, snap_chan_vec=0, snap_time=0, cnt=0, state S_IDLE.
- If cand first goes high in cycle k and stays high, `block` is high from cycle k+DEBOUNCE.
- If cand goes low in cycle j, `block` is low from cycle j+1.
- `block_seen` rises in the same cycle as `block`. Snapshot outputs are valid in that same cycle and show the inputs sampled in cycle k+DEBOUNCE-1.
- `clear_sticky` in cycle c: outputs are cleared from cycle c+1.

## Configuration
- DEADLOCK_MON_SNAPSHOT_EN defined: snapshot registers and timestamp counter are built as described above.
- Not defined: snap_axis_vec, snap_chan_vec and snap_time are tied to 0 and no timestamp counter exists. `block` and `block_seen` behave identically in both builds.

## Structure
- Package hls_deadlock_mon_pkg:
  - state enum (S_IDLE, S_ARM, S_BLOCKED);
  - default TIME_W;
  - function returning the counter width for a given DEBOUNCE.
- Sub-module hls_deadlock_mon_debounce: saturating persistence counter plus FSM. It takes cand, outputs block and an entry pulse, and is parameterised by DEBOUNCE.
- The top computes cand and holds the sticky and snapshot logic.

## Test plan
- NUM_PROC=3, DEBOUNCE=1, AXIS_MASK=3'b101:
  - axis=001, idle=010 in cycle 5 → block=1 in cycle 6, block_seen=1.
  - axis=010 only → cand=0, because the bit is masked.
- DEBOUNCE=4: cand high for 3 cycles, then low for 1, then high for 4 → block never asserts on the first burst; asserts exactly 4 cycles after the second burst starts.
- Block held, then inst_idle_sigs[1] drops in cycle j → block=0 in cycle j+1; block_seen stays 1 until a clear_sticky pulse, then is 0 the following cycle.
- SNAPSHOT_EN, DEBOUNCE=2: first deadlock at cycle 100 with axis=001, chan=110 → snap_time=99, snap_axis_vec=001, snap_chan_vec=110. A second deadlock at cycle 200 leaves the snapshot unchanged; after clear_sticky, a third deadlock recaptures.
- clear_sticky asserted in the same cycle as S_BLOCKED entry → block_seen=1.
- Reset asserted while in S_ARM (cnt=2) → next cycle all outputs are 0; after release, the full DEBOUNCE count is needed again.
